msgdma_line_sequencer: RTL

Frame-fetch controller for the F2H-SDRAM mSGDMA that feeds the HDMI pixel path. It writes one standard-format mSGDMA descriptor per video line to the dispatcher's descriptor slave over an Avalon-MM write master. Descriptor issue is paced by a line-credit counter and restarted on every frame start. It double-buffers the framebuffer base address so the HPS can flip frames without tearing.

---
 rtl/msgdma_line_sequencer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/msgdma_line_sequencer.sv
// Writes one mSGDMA descriptor per video line to the dispatcher descriptor slave.
// Descriptor issue is paced by line credits and restarted on every accepted frame start.
module msgdma_line_sequencer #(
    parameter int unsigned LINE_BYTES      = 7680,
    parameter int unsigned LINE_STRIDE     = 7680,
    parameter int unsigned LINES_PER_FRAME = 1080,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned ADDR_W          = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [ADDR_W-1:0] fb_base_i,
    input  logic              fb_base_load,
    input  logic              frame_start,
    input  logic              line_consumed,
    input  logic              underrun_clr,
    output logic [3:0]        desc_address,
    output logic              desc_write,
    output logic [31:0]       desc_writedata,
    output logic [3:0]        desc_byteenable,
    input  logic              desc_waitrequest,
    output logic [ADDR_W-1:0] active_base,
    output logic              busy,
    output logic              frame_done,
    output logic              underrun
);

    localparam int unsigned IDX_W = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;
    localparam int unsigned CRD_W = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(LINES_PER_FRAME - 1);
    localparam logic [CRD_W-1:0]  CRD_MAX  = CRD_W'(MAX_OUTSTANDING);
    localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(LINE_STRIDE);
    localparam logic [31:0]       LEN_WORD = 32'(LINE_BYTES);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CHECK    = 3'd1;
    localparam logic [2:0] S_WR_RADDR = 3'd2;
    localparam logic [2:0] S_WR_WADDR = 3'd3;
    localparam logic [2:0] S_WR_LEN   = 3'd4;
    localparam logic [2:0] S_WR_CTRL  = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [IDX_W-1:0]  line_idx_q, line_idx_d;
    logic [ADDR_W-1:0] line_addr_q, line_addr_d;
    logic [ADDR_W-1:0] active_base_q, active_base_d;
    logic [CRD_W-1:0]  credits_q, credits_d;
    logic              frame_done_q, frame_done_d;
    logic              underrun_q, underrun_d;
    logic              restart_q, restart_d;
    logic [ADDR_W-1:0] pending_base_q;
    logic              pending_valid_q;

    logic in_write;
    logic ctrl_accept;
    logic start_ok;
    logic do_start;
    logic do_stop;

    assign in_write    = (state_q == S_WR_RADDR) || (state_q == S_WR_WADDR) ||
                         (state_q == S_WR_LEN)   || (state_q == S_WR_CTRL);
    assign ctrl_accept = (state_q == S_WR_CTRL) && !desc_waitrequest;
    assign start_ok    = enable && pending_valid_q;

    always_comb begin
        state_d       = state_q;
        line_idx_d    = line_idx_q;
        line_addr_d   = line_addr_q;
        active_base_d = active_base_q;
        credits_d     = credits_q;
        frame_done_d  = 1'b0;
        underrun_d    = underrun_q;
        restart_d     = restart_q;
        do_start      = 1'b0;
        do_stop       = 1'b0;

        if (ctrl_accept && !line_consumed) begin
            credits_d = credits_q - CRD_W'(1);
        end else if (line_consumed && !ctrl_accept && (credits_q != CRD_MAX)) begin
            credits_d = credits_q + CRD_W'(1);
        end

        if (frame_start && busy) begin
            underrun_d = 1'b1;
        end else if (underrun_clr) begin
            underrun_d = 1'b0;
        end

        // A vsync during a descriptor is remembered so the restart waits for its CTRL word.
        if (frame_start && in_write) begin
            restart_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (frame_start && start_ok) begin
                    do_start = 1'b1;
                end
            end
            S_CHECK: begin
                if (frame_start) begin
                    do_start = start_ok;
                    do_stop  = !start_ok;
                end else if (credits_q != '0) begin
                    state_d = S_WR_RADDR;
                end
            end
            S_WR_RADDR: if (!desc_waitrequest) state_d = S_WR_WADDR;
            S_WR_WADDR: if (!desc_waitrequest) state_d = S_WR_LEN;
            S_WR_LEN:   if (!desc_waitrequest) state_d = S_WR_CTRL;
            S_WR_CTRL: begin
                if (!desc_waitrequest) begin
                    line_idx_d  = line_idx_q + IDX_W'(1);
                    line_addr_d = line_addr_q + STRIDE;
                    if (restart_q || frame_start) begin
                        do_start = start_ok;
                        do_stop  = !start_ok;
                    end else if (line_idx_q == LAST_IDX) begin
                        frame_done_d = 1'b1;
                        do_stop      = 1'b1;
                    end else begin
                        state_d = S_CHECK;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (do_start) begin
            state_d       = S_CHECK;
            active_base_d = pending_base_q;
            line_addr_d   = pending_base_q;
            line_idx_d    = '0;
            credits_d     = CRD_MAX;
            restart_d     = 1'b0;
        end else if (do_stop) begin
            state_d   = S_IDLE;
            restart_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            line_idx_q      <= '0;
            line_addr_q     <= '0;
            active_base_q   <= '0;
            credits_q       <= CRD_MAX;
            frame_done_q    <= 1'b0;
            underrun_q      <= 1'b0;
            restart_q       <= 1'b0;
            pending_base_q  <= '0;
            pending_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            line_idx_q    <= line_idx_d;
            line_addr_q   <= line_addr_d;
            active_base_q <= active_base_d;
            credits_q     <= credits_d;
            frame_done_q  <= frame_done_d;
            underrun_q    <= underrun_d;
            restart_q     <= restart_d;
            if (fb_base_load) begin
                pending_base_q  <= fb_base_i;
                pending_valid_q <= 1'b1;
            end
        end
    end

    // Descriptor words are decoded straight from state so they stay stable under waitrequest.
    always_comb begin
        desc_write     = 1'b0;
        desc_address   = 4'h0;
        desc_writedata = 32'h0;
        case (state_q)
            S_WR_RADDR: begin
                desc_write     = 1'b1;
                desc_address   = 4'h0;
                desc_writedata = 32'(line_addr_q);
            end
            S_WR_WADDR: begin
                desc_write     = 1'b1;
                desc_address   = 4'h4;
            end
            S_WR_LEN: begin
                desc_write     = 1'b1;
                desc_address   = 4'h8;
                desc_writedata = LEN_WORD;
            end
            S_WR_CTRL: begin
                desc_write     = 1'b1;
                desc_address   = 4'hC;
                desc_writedata = {1'b1, 21'b0, (line_idx_q == LAST_IDX), (line_idx_q == '0), 8'b0};
            end
            default: ;
        endcase
    end

    assign desc_byteenable = 4'hF;
    assign active_base     = active_base_q;
    assign busy            = (state_q != S_IDLE);
    assign frame_done      = frame_done_q;
    assign underrun        = underrun_q;

endmodule
